// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the load/store unit (D), instruction fetch (I) and the DMA engine (X).
// Sequences one access at a time, tracks fixed-latency read returns and raises pipeline stalls.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int X_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_mem,
  output logic              stall_fetch
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

  localparam logic [1:0] OWN_D    = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_X    = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [3:0] X_SAT    = 4'(X_MAX_WAIT);

  logic [0:0] state;
  logic [1:0] owner;
  logic [1:0] lat_cnt;
  logic [3:0] x_wait_cnt;
  logic       kill_pend;

  logic [1:0] sel;
  logic       ret_cycle;
  logic       grant_win;
  logic       x_urgent;
  logic       any_gnt;
  logic       win_we;
  logic       d_out;
  logic       i_out;
  logic       kill_now;

  assign ret_cycle = (state == ST_RD_WAIT) && (lat_cnt == LAT_LAST);
  // Grants are suppressed while reset is held so nothing reaches memory during reset.
  assign grant_win = rst && ((state == ST_IDLE) || ret_cycle);
  assign x_urgent  = x_req && (x_wait_cnt == X_SAT);

  always_comb begin
    sel = OWN_NONE;
    if (grant_win) begin
      if (x_urgent)   sel = OWN_X;
      else if (d_req) sel = OWN_D;
      else if (i_req) sel = OWN_I;
      else if (x_req) sel = OWN_X;
    end
  end

  assign d_gnt   = (sel == OWN_D);
  assign i_gnt   = (sel == OWN_I);
  assign x_gnt   = (sel == OWN_X);
  assign any_gnt = (sel != OWN_NONE);

  always_comb begin
    mem_addr  = d_addr;
    mem_wdata = d_wdata;
    mem_be    = d_be;
    win_we    = d_we;
    case (sel)
      OWN_I: begin
        mem_addr = i_addr;
        mem_be   = 4'hF;
        win_we   = 1'b0;
      end
      OWN_X: begin
        mem_addr  = x_addr;
        mem_wdata = x_wdata;
        mem_be    = 4'hF;
        win_we    = x_we;
      end
      default: ;
    endcase
  end

  assign mem_en = any_gnt;
  assign mem_we = any_gnt && win_we;

  assign d_out = (state == ST_RD_WAIT) && (owner == OWN_D);
  assign i_out = (state == ST_RD_WAIT) && (owner == OWN_I);
  // A kill arriving in the same cycle must already hide the fetch return and its stall.
  assign kill_now = kill_pend || (i_kill && i_out);

  assign d_rvalid = ret_cycle && (owner == OWN_D);
  assign i_rvalid = ret_cycle && (owner == OWN_I) && !kill_now;
  assign x_rvalid = ret_cycle && (owner == OWN_X);
  assign d_rdata  = mem_rdata;
  assign i_rdata  = mem_rdata;
  assign x_rdata  = mem_rdata;

  assign stall_mem   = rst && ((d_req && !d_gnt) || (d_out && !d_rvalid));
  assign stall_fetch = rst && ((i_req && !i_gnt) || (i_out && !i_rvalid && !kill_now));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_D;
      lat_cnt    <= 2'd0;
      x_wait_cnt <= 4'd0;
      kill_pend  <= 1'b0;
    end else begin
      if (any_gnt && !win_we) begin
        state   <= ST_RD_WAIT;
        lat_cnt <= 2'd0;
        owner   <= sel;
      end else if (ret_cycle) begin
        state   <= ST_IDLE;
        lat_cnt <= 2'd0;
      end else if (state == ST_RD_WAIT) begin
        lat_cnt <= lat_cnt + 2'd1;
      end

      // A return cycle retires the old kill; only a freshly killed new fetch keeps it set.
      if (ret_cycle)
        kill_pend <= i_gnt && i_kill;
      else if ((i_gnt && i_kill) || (i_kill && i_out))
        kill_pend <= 1'b1;

      if (!x_req || x_gnt)
        x_wait_cnt <= 4'd0;
      else if (x_wait_cnt != X_SAT)
        x_wait_cnt <= x_wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single-grant vectors plus multi-cycle sequences.
// A small memory model returns a fixed function of the address RD_LAT cycles after each read.
module tb_mem_port_arbiter;

  localparam int RD_LAT     = 2;
  localparam int X_MAX_WAIT = 8;

  logic        clk;
  logic        rst;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        i_req, i_kill;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        x_req, x_we;
  logic [31:0] x_addr, x_wdata;
  logic        x_gnt, x_rvalid;
  logic [31:0] x_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall_mem, stall_fetch;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .X_MAX_WAIT(X_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .stall_mem(stall_mem), .stall_fetch(stall_fetch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents are a fixed function of the address, with one special word.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_addr : 32'h0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = mem_model(rd_pipe[RD_LAT-1]);

  typedef struct {
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic        i_req;
    logic [31:0] i_addr;
    logic        x_req, x_we;
    logic [31:0] x_addr;
    logic        exp_d_gnt, exp_i_gnt, exp_x_gnt, exp_en, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [6];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    i_req = 0; i_addr = 0; i_kill = 0;
    x_req = 0; x_we = 0; x_addr = 0; x_wdata = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = 32'h1111_0000;
    i_req = v.i_req; i_addr = v.i_addr;
    x_req = v.x_req; x_we = v.x_we; x_addr = v.x_addr; x_wdata = 32'h2222_0000;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;

    // Reset: a pending request must not produce any activity while reset is held.
    d_req = 1; i_req = 1;
    #12;
    checkOutput("rst_d_gnt", 32'(d_gnt), 0);
    checkOutput("rst_mem_en", 32'(mem_en), 0);
    checkOutput("rst_stall_mem", 32'(stall_mem), 0);
    checkOutput("rst_stall_fetch", 32'(stall_fetch), 0);
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    #1;
    checkOutput("post_rst_mem_en", 32'(mem_en), 0);
    checkOutput("post_rst_stall_fetch", 32'(stall_fetch), 0);
    next_cycle();

    // d_req d_we d_be d_addr i_req i_addr x_req x_we x_addr | d i x en we be addr
    vecs[0] = '{1, 1, 4'b0011, 32'h10, 1, 32'h20, 1, 0, 32'h30, 1, 0, 0, 1, 1, 4'b0011, 32'h10};
    vecs[1] = '{0, 0, 4'b0000, 32'h0,  1, 32'h24, 0, 0, 32'h0,  0, 1, 0, 1, 0, 4'hF,    32'h24};
    vecs[2] = '{0, 0, 4'b0000, 32'h0,  0, 32'h0,  1, 1, 32'h34, 0, 0, 1, 1, 1, 4'hF,    32'h34};
    vecs[3] = '{1, 0, 4'b1100, 32'h18, 0, 32'h0,  1, 0, 32'h38, 1, 0, 0, 1, 0, 4'b1100, 32'h18};
    vecs[4] = '{0, 0, 4'b0000, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 4'b0000, 32'h0};
    vecs[5] = '{0, 0, 4'b0000, 32'h0,  1, 32'h28, 1, 0, 32'h3C, 0, 1, 0, 1, 0, 4'hF,    32'h28};

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].exp_d_gnt));
      checkOutput($sformatf("vec%0d_i_gnt", i), 32'(i_gnt), 32'(vecs[i].exp_i_gnt));
      checkOutput($sformatf("vec%0d_x_gnt", i), 32'(x_gnt), 32'(vecs[i].exp_x_gnt));
      checkOutput($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].exp_en));
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_en) begin
        checkOutput($sformatf("vec%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
        checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      end
      next_cycle();
      clear_inputs();
      next_cycle();
      next_cycle();
    end

    // D read with I also requesting: I waits for the return cycle.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
    i_req = 1; i_addr = 32'h200;
    #1;
    checkOutput("b2b_t0_d_gnt", 32'(d_gnt), 1);
    checkOutput("b2b_t0_i_gnt", 32'(i_gnt), 0);
    checkOutput("b2b_t0_stall_fetch", 32'(stall_fetch), 1);
    next_cycle();
    d_req = 0;
    #1;
    checkOutput("b2b_t1_d_gnt", 32'(d_gnt), 0);
    checkOutput("b2b_t1_i_gnt", 32'(i_gnt), 0);
    checkOutput("b2b_t1_stall_fetch", 32'(stall_fetch), 1);
    checkOutput("b2b_t1_stall_mem", 32'(stall_mem), 1);
    next_cycle();
    checkOutput("b2b_t2_i_gnt", 32'(i_gnt), 1);
    checkOutput("b2b_t2_d_rvalid", 32'(d_rvalid), 1);
    checkOutput("b2b_t2_d_rdata", d_rdata, 32'hDEADBEEF);
    checkOutput("b2b_t2_mem_addr", mem_addr, 32'h200);
    checkOutput("b2b_t2_stall_mem", 32'(stall_mem), 0);
    next_cycle();
    i_req = 0;
    #1;
    checkOutput("b2b_t3_i_rvalid", 32'(i_rvalid), 0);
    checkOutput("b2b_t3_stall_fetch", 32'(stall_fetch), 1);
    next_cycle();
    checkOutput("b2b_t4_i_rvalid", 32'(i_rvalid), 1);
    checkOutput("b2b_t4_i_rdata", i_rdata, 32'h0200FDFF);
    next_cycle();
    clear_inputs();

    // Three back-to-back D writes.
    for (int k = 0; k < 3; k++) begin
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h40 + 32'(4 * k); d_wdata = 32'(k);
      #1;
      checkOutput($sformatf("wr%0d_d_gnt", k), 32'(d_gnt), 1);
      checkOutput($sformatf("wr%0d_mem_we", k), 32'(mem_we), 1);
      checkOutput($sformatf("wr%0d_mem_be", k), 32'(mem_be), 32'b0011);
      checkOutput($sformatf("wr%0d_mem_addr", k), mem_addr, 32'h40 + 32'(4 * k));
      checkOutput($sformatf("wr%0d_d_rvalid", k), 32'(d_rvalid), 0);
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // X starvation: D writes and I saturate, X wins every X_MAX_WAIT+1 cycles.
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h50;
    i_req = 1; i_addr = 32'h60;
    x_req = 1; x_we = 1; x_addr = 32'h70;
    for (int k = 1; k <= 2 * (X_MAX_WAIT + 1); k++) begin
      logic exp_x;
      exp_x = (k == X_MAX_WAIT + 1) || (k == 2 * (X_MAX_WAIT + 1));
      #1;
      checkOutput($sformatf("starve%0d_x_gnt", k), 32'(x_gnt), 32'(exp_x));
      checkOutput($sformatf("starve%0d_d_gnt", k), 32'(d_gnt), 32'(!exp_x));
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Killed fetch: no return, no stall, and a new fetch may go in the return cycle.
    i_req = 1; i_addr = 32'h300;
    #1;
    checkOutput("kill_t0_i_gnt", 32'(i_gnt), 1);
    next_cycle();
    i_req = 0; i_kill = 1;
    #1;
    checkOutput("kill_t1_stall_fetch", 32'(stall_fetch), 0);
    next_cycle();
    i_kill = 0; i_req = 1; i_addr = 32'h304;
    #1;
    checkOutput("kill_t2_i_rvalid", 32'(i_rvalid), 0);
    checkOutput("kill_t2_i_gnt", 32'(i_gnt), 1);
    checkOutput("kill_t2_stall_fetch", 32'(stall_fetch), 0);
    next_cycle();
    i_req = 0;
    #1;
    checkOutput("kill_t3_i_rvalid", 32'(i_rvalid), 0);
    checkOutput("kill_t3_stall_fetch", 32'(stall_fetch), 1);
    next_cycle();
    checkOutput("kill_t4_i_rvalid", 32'(i_rvalid), 1);
    checkOutput("kill_t4_i_rdata", i_rdata, 32'h0304FCFB);
    next_cycle();
    clear_inputs();

    // Reset one cycle before a D read returns: the read vanishes.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40;
    #1;
    checkOutput("rstrd_t0_d_gnt", 32'(d_gnt), 1);
    next_cycle();
    d_req = 0;
    rst = 1'b0;
    #1;
    checkOutput("rstrd_t1_d_rvalid", 32'(d_rvalid), 0);
    checkOutput("rstrd_t1_stall_mem", 32'(stall_mem), 0);
    checkOutput("rstrd_t1_mem_en", 32'(mem_en), 0);
    next_cycle();
    checkOutput("rstrd_t2_d_rvalid", 32'(d_rvalid), 0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("rstrd_rel%0d_d_rvalid", k), 32'(d_rvalid), 0);
      checkOutput($sformatf("rstrd_rel%0d_stall_mem", k), 32'(stall_mem), 0);
      next_cycle();
    end
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h44;
    #1;
    checkOutput("cold_d_gnt", 32'(d_gnt), 1);
    next_cycle();
    d_req = 0;
    #1;
    checkOutput("cold_t1_d_rvalid", 32'(d_rvalid), 0);
    next_cycle();
    checkOutput("cold_t2_d_rvalid", 32'(d_rvalid), 1);
    checkOutput("cold_t2_d_rdata", d_rdata, 32'h0044FFBB);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
